// File: rtl/punc_control_unit.sv
// LC3 control FSM for the PUnC processor: sequences FETCH/DECODE/EXEC plus
// EXEC2 (indirect) and SETCC (load condition codes), issuing Moore strobes.
module punc_control_unit #(
  parameter logic [3:0] HALT_OPCODE   = 4'b1111,
  parameter bit         SETCC_ON_LOAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  output logic        mem_wr_en,
  output logic [2:0]  mem_r_addr_sel,
  output logic        state2_STI,
  output logic        STR,
  output logic [2:0]  RF_wr_addr,
  output logic        RF_wr_en,
  output logic [2:0]  RF_r_addr_0,
  output logic [2:0]  RF_r_addr_1,
  output logic [1:0]  RF_w_data_sel,
  output logic        ir_ld,
  output logic        JMP_RET_JSRR,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        add_const,
  output logic [1:0]  alu_sel,
  output logic        cc_en,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [10:0] const_n,
  output logic [3:0]  SEXT_Select,
  output logic        halted
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_NOT  = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_SETCC  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_after_load;
  logic [3:0] w_op;
  logic [2:0] w_dr;
  logic [2:0] w_br;

  assign w_op         = ir[15:12];
  assign w_dr         = ir[11:9];
  assign w_br         = ir[8:6];
  assign w_after_load = SETCC_ON_LOAD ? S_SETCC : S_FETCH;
  assign const_n      = ir[10:0];

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode; reset suppresses every strobe but pc_clr
  always_comb begin
    w_next         = r_state;
    mem_wr_en      = 1'b0;
    mem_r_addr_sel = 3'd0;
    state2_STI     = 1'b0;
    STR            = 1'b0;
    RF_wr_addr     = 3'd0;
    RF_wr_en       = 1'b0;
    RF_r_addr_0    = 3'd0;
    RF_r_addr_1    = 3'd0;
    RF_w_data_sel  = 2'd0;
    ir_ld          = 1'b0;
    JMP_RET_JSRR   = 1'b0;
    pc_ld          = 1'b0;
    pc_clr         = 1'b0;
    pc_up          = 1'b0;
    add_const      = 1'b0;
    alu_sel        = ALU_PASS;
    cc_en          = 1'b0;
    n              = 1'b0;
    z              = 1'b0;
    p              = 1'b0;
    SEXT_Select    = 4'b0000;
    halted         = 1'b0;
    if (!rst) begin
      pc_clr = 1'b1;
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_r_addr_sel = 3'd0;
          ir_ld          = 1'b1;
          pc_up          = 1'b1;
          w_next         = S_DECODE;
        end
        S_DECODE: begin
          if (w_op == HALT_OPCODE) begin
            w_next = S_HALT;
          end else begin
            w_next = S_EXEC;
          end
        end
        S_EXEC: begin
          w_next = S_FETCH;
          case (w_op)
            OP_ADD, OP_AND: begin
              RF_r_addr_0 = w_br;
              if (ir[5]) begin
                add_const   = 1'b1;
                SEXT_Select = 4'b1000;
              end else begin
                RF_r_addr_1 = ir[2:0];
              end
              alu_sel    = (w_op == OP_ADD) ? ALU_ADD : ALU_AND;
              RF_wr_addr = w_dr;
              RF_wr_en   = 1'b1;
              cc_en      = 1'b1;
            end
            OP_NOT: begin
              RF_r_addr_0 = w_br;
              alu_sel     = ALU_NOT;
              RF_wr_addr  = w_dr;
              RF_wr_en    = 1'b1;
              cc_en       = 1'b1;
            end
            OP_BR: begin
              n           = ir[11];
              z           = ir[10];
              p           = ir[9];
              SEXT_Select = 4'b0010;
            end
            OP_JMP: begin
              RF_r_addr_0  = w_br;
              JMP_RET_JSRR = 1'b1;
              pc_ld        = 1'b1;
            end
            OP_JSR: begin
              RF_wr_addr    = 3'd7;
              RF_wr_en      = 1'b1;
              RF_w_data_sel = 2'd1;
              pc_ld         = 1'b1;
              if (ir[11]) begin
                SEXT_Select = 4'b0001;
              end else begin
                RF_r_addr_0  = w_br;
                JMP_RET_JSRR = 1'b1;
              end
            end
            OP_LD: begin
              mem_r_addr_sel = 3'd1;
              SEXT_Select    = 4'b0010;
              RF_w_data_sel  = 2'd2;
              RF_wr_addr     = w_dr;
              RF_wr_en       = 1'b1;
              w_next         = w_after_load;
            end
            OP_LEA: begin
              SEXT_Select   = 4'b0010;
              RF_w_data_sel = 2'd3;
              RF_wr_addr    = w_dr;
              RF_wr_en      = 1'b1;
              w_next        = w_after_load;
            end
            OP_LDR: begin
              RF_r_addr_0    = w_br;
              add_const      = 1'b1;
              SEXT_Select    = 4'b0100;
              alu_sel        = ALU_ADD;
              mem_r_addr_sel = 3'd4;
              RF_w_data_sel  = 2'd2;
              RF_wr_addr     = w_dr;
              RF_wr_en       = 1'b1;
              w_next         = w_after_load;
            end
            OP_LDI, OP_STI: begin
              mem_r_addr_sel = 3'd1;
              SEXT_Select    = 4'b0010;
              w_next         = S_EXEC2;
            end
            OP_ST: begin
              RF_r_addr_0 = w_dr;
              SEXT_Select = 4'b0010;
              mem_wr_en   = 1'b1;
            end
            OP_STR: begin
              STR         = 1'b1;
              RF_r_addr_0 = w_br;
              RF_r_addr_1 = w_dr;
              add_const   = 1'b1;
              SEXT_Select = 4'b0100;
              alu_sel     = ALU_ADD;
              mem_wr_en   = 1'b1;
            end
            default: begin
              w_next = S_FETCH;
            end
          endcase
        end
        S_EXEC2: begin
          w_next = S_FETCH;
          if (w_op == OP_LDI) begin
            mem_r_addr_sel = 3'd2;
            RF_w_data_sel  = 2'd2;
            RF_wr_addr     = w_dr;
            RF_wr_en       = 1'b1;
            w_next         = w_after_load;
          end else if (w_op == OP_STI) begin
            state2_STI  = 1'b1;
            RF_r_addr_0 = w_dr;
            mem_wr_en   = 1'b1;
          end else begin
            w_next = S_FETCH;
          end
        end
        S_SETCC: begin
          RF_r_addr_0 = w_dr;
          cc_en       = 1'b1;
          w_next      = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
          w_next = S_HALT;
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control_unit.sv
// Randomized bench for punc_control_unit: per-cycle strobe vectors are compared
// against a model built from each opcode's cycle-by-cycle behaviour.
module tb_punc_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        mem_wr_en, state2_STI, STR, RF_wr_en, ir_ld, JMP_RET_JSRR;
  logic        pc_ld, pc_clr, pc_up, add_const, cc_en, n, z, p, halted;
  logic [2:0]  mem_r_addr_sel, RF_wr_addr, RF_r_addr_0, RF_r_addr_1;
  logic [1:0]  RF_w_data_sel, alu_sel;
  logic [10:0] const_n;
  logic [3:0]  SEXT_Select;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        mem_wr_en;
    logic [2:0]  sel;
    logic        sti2;
    logic        str;
    logic [2:0]  wr_addr;
    logic        wr_en;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [1:0]  wsel;
    logic        ir_ld;
    logic        jmp;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_up;
    logic        add_const;
    logic [1:0]  alu;
    logic        cc_en;
    logic [2:0]  nzp;
    logic [10:0] const_n;
    logic [3:0]  sext;
    logic        halted;
  } ctl_t;

  ctl_t got;

  always #5 clk = ~clk;

  punc_control_unit dut (
    .clk(clk), .rst(rst), .ir(ir),
    .mem_wr_en(mem_wr_en), .mem_r_addr_sel(mem_r_addr_sel), .state2_STI(state2_STI),
    .STR(STR), .RF_wr_addr(RF_wr_addr), .RF_wr_en(RF_wr_en),
    .RF_r_addr_0(RF_r_addr_0), .RF_r_addr_1(RF_r_addr_1), .RF_w_data_sel(RF_w_data_sel),
    .ir_ld(ir_ld), .JMP_RET_JSRR(JMP_RET_JSRR), .pc_ld(pc_ld), .pc_clr(pc_clr),
    .pc_up(pc_up), .add_const(add_const), .alu_sel(alu_sel), .cc_en(cc_en),
    .n(n), .z(z), .p(p), .const_n(const_n), .SEXT_Select(SEXT_Select), .halted(halted)
  );

  assign got = {mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
                RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR, pc_ld,
                pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p, const_n,
                SEXT_Select, halted};

  task automatic check_eq(input string tag, input ctl_t obs, input ctl_t exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s ir=%h got=%h expected=%h", tag, ir, obs, exp_v);
    end
  endtask

  // Cycles an instruction occupies from FETCH until the next FETCH.
  function automatic int instr_len(input logic [15:0] v);
    case (v[15:12])
      4'b1111:                   return 2;
      4'b0010, 4'b0110, 4'b1110: return 4;
      4'b1011:                   return 4;
      4'b1010:                   return 5;
      default:                   return 3;
    endcase
  endfunction

  // Expected strobes in cycle k of instruction v (k=0 is FETCH).
  function automatic ctl_t model(input logic [15:0] v, input int k,
                                 input bit in_rst, input bit in_halt);
    ctl_t e;
    logic [3:0] op;
    logic [2:0] dr, br;
    int last;
    e = '0;
    e.const_n = v[10:0];
    op = v[15:12];
    dr = v[11:9];
    br = v[8:6];
    last = instr_len(v) - 1;
    if (in_rst) begin
      e.pc_clr = 1'b1;
    end else if (in_halt) begin
      e.halted = 1'b1;
    end else if (k == 0) begin
      e.ir_ld = 1'b1;
      e.pc_up = 1'b1;
    end else if (k == 1) begin
      e.pc_up = 1'b0;
    end else if (k == last && (op == 4'b0010 || op == 4'b0110 || op == 4'b1110 || op == 4'b1010)) begin
      e.r0 = dr; e.cc_en = 1'b1;                       // condition-code cycle after a load
    end else if (k == 3) begin
      if (op == 4'b1010) begin
        e.sel = 3'd2; e.wsel = 2'd2; e.wr_addr = dr; e.wr_en = 1'b1;
      end else begin
        e.sti2 = 1'b1; e.r0 = dr; e.mem_wr_en = 1'b1;
      end
    end else begin
      case (op)
        4'b0001, 4'b0101: begin
          e.r0 = br;
          if (v[5]) begin e.add_const = 1'b1; e.sext = 4'b1000; end
          else e.r1 = v[2:0];
          e.alu = (op == 4'b0001) ? 2'd1 : 2'd2;
          e.wr_addr = dr; e.wr_en = 1'b1; e.cc_en = 1'b1;
        end
        4'b1001: begin e.r0 = br; e.alu = 2'd3; e.wr_addr = dr; e.wr_en = 1'b1; e.cc_en = 1'b1; end
        4'b0000: begin e.nzp = v[11:9]; e.sext = 4'b0010; end
        4'b1100: begin e.r0 = br; e.jmp = 1'b1; e.pc_ld = 1'b1; end
        4'b0100: begin
          e.wr_addr = 3'd7; e.wr_en = 1'b1; e.wsel = 2'd1; e.pc_ld = 1'b1;
          if (v[11]) e.sext = 4'b0001;
          else begin e.r0 = br; e.jmp = 1'b1; end
        end
        4'b0010: begin e.sel = 3'd1; e.sext = 4'b0010; e.wsel = 2'd2; e.wr_addr = dr; e.wr_en = 1'b1; end
        4'b1110: begin e.sext = 4'b0010; e.wsel = 2'd3; e.wr_addr = dr; e.wr_en = 1'b1; end
        4'b0110: begin
          e.r0 = br; e.add_const = 1'b1; e.sext = 4'b0100; e.alu = 2'd1;
          e.sel = 3'd4; e.wsel = 2'd2; e.wr_addr = dr; e.wr_en = 1'b1;
        end
        4'b1010, 4'b1011: begin e.sel = 3'd1; e.sext = 4'b0010; end
        4'b0011: begin e.r0 = dr; e.sext = 4'b0010; e.mem_wr_en = 1'b1; end
        4'b0111: begin
          e.str = 1'b1; e.r0 = br; e.r1 = dr; e.add_const = 1'b1;
          e.sext = 4'b0100; e.alu = 2'd1; e.mem_wr_en = 1'b1;
        end
        default: e.halted = 1'b0;
      endcase
    end
    return e;
  endfunction

  // Runs one instruction from FETCH; rst_at >= 0 pulls reset in that cycle.
  task automatic run_instr(input logic [15:0] new_ir, input int rst_at);
    int len;
    len = instr_len(new_ir);
    for (int k = 0; k < len; k++) begin
      if (k == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_reset", got, model(ir, 0, 1'b1, 1'b0));
        @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      @(negedge clk);
      check_eq(k == 0 ? "fetch" : (k == 1 ? "decode" : "exec"), got, model(ir, k, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      if (k == 0) ir = new_ir;
    end
    if (new_ir[15:12] == 4'b1111) begin
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        check_eq("halt", got, model(ir, 0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
      end
      rst = 1'b0;
      @(negedge clk);
      check_eq("halt_reset", got, model(ir, 0, 1'b1, 1'b0));
      @(posedge clk);
      #1 rst = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] v;
    int ra;
    rst = 1'b0;
    ir  = 16'h0000;
    @(negedge clk);
    check_eq("reset", got, model(ir, 0, 1'b1, 1'b0));
    @(posedge clk);
    #1 rst = 1'b1;

    run_instr(16'h1239, -1);
    run_instr(16'hA402, -1);
    run_instr(16'h0404, -1);
    run_instr(16'h41C0, -1);
    run_instr(16'hB602, -1);
    run_instr(16'h5A85, -1);
    run_instr(16'h7E7F, -1);
    run_instr(16'hA402, 3);
    run_instr(16'h2A10, -1);
    run_instr(16'hF025, -1);

    for (int i = 0; i < 300; i++) begin
      v  = 16'($urandom());
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, instr_len(v) - 1) : -1;
      run_instr(v, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
